// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the receiver)
// and default frame parameters.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line.
// Runs off a shared b_tick (OVERSAMPLE pulses per bit). A one-entry holding
// register takes the next byte while the current frame shifts out, so
// consecutive frames leave back-to-back with no idle gap.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   b_tick    in   one-clk pulse at OVERSAMPLE x baud
//   tx_start  in   write strobe, accepted only while tx_ready=1
//   tx_data   in   byte to send, sampled on an accepted tx_start
//   tx        out  serial line (registered)
//   tx_ready  out  holding register empty
//   tx_busy   out  FSM not in IDLE
//   tx_done   out  one-clk pulse at the end of each stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  uart_state_e          r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift_reg;
  logic [DATA_BITS-1:0] r_hold_reg;
  logic                 r_hold_valid;
  logic                 r_tx;
  logic                 r_tx_done;
  logic                 r_tx_busy;
  logic                 r_tx_ready;

  uart_state_e          w_state_nxt;
  logic [TICK_W-1:0]    w_tick_cnt_nxt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift_reg_nxt;
  logic [DATA_BITS-1:0] w_hold_reg_nxt;
  logic                 w_hold_valid_nxt;
  logic                 w_tx_nxt;
  logic                 w_tx_done_nxt;
  logic                 w_tick_last;
  logic                 w_bit_last;
  logic                 w_accept;

  assign w_tick_last = (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign w_bit_last  = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
  assign w_accept    = tx_start & ~r_hold_valid;

  // Next-state, counters, shift/hold datapath and registered-output values
  always_comb begin
    w_state_nxt      = r_state;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_reg_nxt  = r_shift_reg;
    w_hold_reg_nxt   = r_hold_reg;
    w_hold_valid_nxt = r_hold_valid;
    w_tx_done_nxt    = 1'b0;
    w_tx_nxt         = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (b_tick && r_hold_valid) begin
          w_shift_reg_nxt  = r_hold_reg;
          w_hold_valid_nxt = 1'b0;
          w_tick_cnt_nxt   = '0;
          w_state_nxt      = START;
        end
      end
      START: begin
        if (b_tick) begin
          if (w_tick_last) begin
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = DATA;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (w_tick_last) begin
            w_tick_cnt_nxt = '0;
            if (w_bit_last) begin
              w_state_nxt = STOP;
            end else begin
              w_shift_reg_nxt = r_shift_reg >> 1;
              w_bit_cnt_nxt   = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (w_tick_last) begin
            w_tx_done_nxt  = 1'b1;
            w_tick_cnt_nxt = '0;
            // Reload straight into START when a byte is waiting: no idle gap
            if (r_hold_valid) begin
              w_shift_reg_nxt  = r_hold_reg;
              w_hold_valid_nxt = 1'b0;
              w_state_nxt      = START;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A legal accept always wins over a drain on the same edge
    if (w_accept) begin
      w_hold_reg_nxt   = tx_data;
      w_hold_valid_nxt = 1'b1;
    end

    // Line level follows the current state, landing one clk after it
    unique case (r_state)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_shift_reg[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift_reg  <= '0;
      r_hold_reg   <= '0;
      r_hold_valid <= 1'b0;
      r_tx         <= 1'b1;
      r_tx_done    <= 1'b0;
      r_tx_busy    <= 1'b0;
      r_tx_ready   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift_reg  <= w_shift_reg_nxt;
      r_hold_reg   <= w_hold_reg_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_tx         <= w_tx_nxt;
      r_tx_done    <= w_tx_done_nxt;
      r_tx_busy    <= (w_state_nxt != IDLE);
      r_tx_ready   <= ~w_hold_valid_nxt;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_tx_ready;
  assign tx_busy  = r_tx_busy;
  assign tx_done  = r_tx_done;

endmodule : uart_tx
